// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types, defaults and width helper for the ADC sample sequencer
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CONVERT = 2'd2,
    EVAL    = 2'd3
  } adc_seq_state_t;

  localparam int          ADC_W_DEF     = 12;
  localparam logic [11:0] THRESH_HI_DEF = 12'h800;
  localparam logic [11:0] THRESH_LO_DEF = 12'h7C0;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// rtl/adc_avg_accum.sv - sample accumulator with count, truncating average and last-sample flag
module adc_avg_accum #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             add,
  input  logic [ADC_W-1:0] sample,
  output logic [ADC_W-1:0] avg,
  output logic             last
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= acc + ACC_W'(sample);
      cnt <= cnt + 1'b1;
    end
  end

  // The sample being added now completes the set.
  assign last = (cnt == CNT_W'((2 ** AVG_LOG2) - 1));
  assign avg  = acc[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - periodic ADC start/capture, averaging and hysteresis decision
// Define ADC_SEQ_DEBOUNCE_EN to require two consecutive agreeing EVALs before ADC_comp changes.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int ADC_W    = ADC_W_DEF,
  parameter int PERIOD   = 400,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             swiptAlive,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [ADC_W-1:0] thresh_hi,
  input  logic [ADC_W-1:0] thresh_lo,
  output logic             adc_start,
  output logic [ADC_W-1:0] avg_out,
  output logic             avg_valid,
  output logic             ADC_comp,
  output logic             timeout_err
);

  localparam int PCNT_W = clog2(PERIOD);
  localparam int TCNT_W = clog2(TIMEOUT);
  localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PERIOD - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  generate
    if (TIMEOUT + 3 >= PERIOD) begin : g_bad_cfg
      $error("adc_sample_sequencer: TIMEOUT+3 must be less than PERIOD");
    end
  endgenerate

  adc_seq_state_t    state, state_nxt;
  logic [PCNT_W-1:0] pcnt;
  logic [TCNT_W-1:0] tcnt;
  logic              start_nxt, acc_clear, acc_add, to_hit;
  logic [ADC_W-1:0]  avg;
  logic              acc_last;
  logic              above_hi, below_lo, cmp_change;

  adc_avg_accum #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_accum (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (acc_clear),
    .add    (acc_add),
    .sample (adc_data),
    .avg    (avg),
    .last   (acc_last)
  );

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    to_hit    = 1'b0;
    if (!swiptAlive) begin
      state_nxt = IDLE;
      acc_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = CONVERT;
          start_nxt = 1'b1;
        end
        WAIT: begin
          if (pcnt == '0) begin
            state_nxt = CONVERT;
            start_nxt = 1'b1;
          end
        end
        CONVERT: begin
          // A done in the expiry cycle is still taken as a good sample.
          if (adc_done) begin
            acc_add   = 1'b1;
            state_nxt = acc_last ? EVAL : WAIT;
          end else if (tcnt == TCNT_LAST) begin
            to_hit    = 1'b1;
            state_nxt = WAIT;
          end
        end
        EVAL: begin
          acc_clear = 1'b1;
          state_nxt = WAIT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      adc_start   <= 1'b0;
      pcnt        <= '0;
      tcnt        <= '0;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      adc_start <= start_nxt;
      avg_valid <= 1'b0;
      if (!swiptAlive) begin
        pcnt        <= '0;
        tcnt        <= '0;
        avg_out     <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (start_nxt) begin
          pcnt <= PCNT_LOAD;
        end else if (state != IDLE) begin
          pcnt <= pcnt - 1'b1;
        end
        tcnt <= (state == CONVERT && state_nxt == CONVERT) ? tcnt + 1'b1 : '0;
        if (to_hit) timeout_err <= 1'b1;
        if (state == EVAL) begin
          avg_out   <= avg;
          avg_valid <= 1'b1;
        end
      end
    end
  end

  // The upper test wins when the thresholds are inverted; equality holds.
  assign above_hi   = (avg > thresh_hi);
  assign below_lo   = (avg < thresh_lo);
  assign cmp_change = above_hi ? ADC_comp : (below_lo & ~ADC_comp);

`ifdef ADC_SEQ_DEBOUNCE_EN
  logic pend;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ADC_comp <= 1'b0;
      pend     <= 1'b0;
    end else if (!swiptAlive) begin
      ADC_comp <= 1'b0;
      pend     <= 1'b0;
    end else if (state == EVAL) begin
      if (cmp_change) begin
        if (pend) begin
          ADC_comp <= ~ADC_comp;
          pend     <= 1'b0;
        end else begin
          pend <= 1'b1;
        end
      end else begin
        pend <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ADC_comp <= 1'b0;
    end else if (!swiptAlive) begin
      ADC_comp <= 1'b0;
    end else if (state == EVAL && cmp_change) begin
      ADC_comp <= ~ADC_comp;
    end
  end
`endif

endmodule
